clos_cm_sync_buf: RTL and testbench
===================================

Name: clos_cm_sync_buf

Overview:
- Clocked, parametrised successor to the Clos centre module (CM) for the buffered SDM-Clos router.
- KN input ports are switched to KN output ports with wormhole (eof-terminated) packet locking and a per-output round-robin arbiter.
- Each output has a BD-deep FIFO, which decouples CM arbitration from OM back-pressure.
- Sits between the IM and OM stages; each port carries one DW-bit virtual-circuit lane plus eof.

Parameters:
- KN, 5, number of input and output ports.
- DW, 8, data width of one port (excludes eof).
- BD, 4, output FIFO depth; power of two, >=2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- di  input  KN*DW  input flit data; port i occupies bits [i*DW +: DW].
- di4  input  KN  input eof bit; 1 marks the last flit of a packet.
- div  input  KN  input flit valid.
- dreq  input  KN*KN  routing request; bits [i*KN +: KN] are the one-hot target output of input i, held for the whole packet.
- dia  output  KN  input ack/ready; a flit transfers when div[i] & dia[i] are both high.
- do  output  KN*DW  output flit data, taken from the FIFO head.
- do4  output  KN  output eof, taken from the FIFO head.
- dov  output  KN  output valid.
- doa  input  KN  output ack/ready from the OM; the FIFO pops when dov[j] & doa[j] are both high.
- obusy  output  KN  output j is locked to an input packet.

Behaviour:
- Reset (async, rst_n=0) clears:
  - all FIFO counts and pointers, so dov=0 and do/do4 are don't-care (driven 0);
  - all locks, so obusy=0 and dia=0;
  - every round-robin pointer, to KN-1, so input 0 has first priority.
- Reset asserted mid-packet discards buffered flits and locks; no partial-packet recovery.
- Request decode: an effective request is req[i][j] = div[i] & dreq[i][j].
  - A multi-hot dreq is illegal; hardware uses the lowest set bit only.
  - All-zero dreq means no request and no ack.
- Per-output FSM, two states:
  - IDLE -> LOCKED(owner=k) when any effective request targets j. k is the first requester after ptr[j], scanning cyclically upward. The lock is registered, so no flit moves in the grant cycle.
  - LOCKED: transfer when div[owner] & !full[j]. A transfer sets dia[owner]=1 and pushes {di4, di} into FIFO j.
  - LOCKED -> IDLE at the clock edge where the transferred flit has di4=1; ptr[j] <= owner at that edge.
  - A lock persists across bubbles (div low) and FIFO-full stalls. No timeout.
- dia[i] = OR over j of (locked_j & owner_j==i & !full_j). It is combinational from registered state and FIFO count only; it never depends on div. Only one j can match because requests are one-hot.
- Contention: each output is arbitrated independently. Different outputs may lock different inputs in the same cycle, which gives full non-blocking crossbar throughput.
- FIFO:
  - count width is clog2(BD+1); full = (count==BD); dov[j] = (count!=0).
  - Push and pop in the same cycle are allowed when 0<count<BD; count is unchanged.
  - Full is evaluated before pop, so no write occurs into a full FIFO even when it pops that cycle.
  - No write-through bypass: minimum head-flit latency is 2 cycles from request (lock cycle plus write cycle); body flits have 1 cycle latency.
  - Pointers wrap modulo BD.
- Throughput: 1 flit/cycle per output once locked, with sustained doa=1.
- obusy[j] = locked_j (registered).
- No data-width arithmetic; data passes through unmodified, and eof stays aligned with its flit through the FIFO.

Test Plan:
1. Single packet, KN=5, DW=8, BD=4, doa=1:
   - stimulus: input 2 sends a 3-flit packet (0x11, 0x22, 0x33 with eof) to output 4;
   - response: obusy[4]=1 from cycle 1; dov[4] first at cycle 2; do4[4]=1 on 0x33; obusy[4]=0 after the eof transfer.
2. Contention:
   - stimulus: inputs 0, 1 and 3 all request output 1 at cycle 0 with 2-flit packets;
   - response: grant order 0, 1, 3; packets are never interleaved; ptr ends at 3.
3. Back-pressure:
   - stimulus: doa[0]=0 while a 6-flit packet targets output 0;
   - response: 4 flits are accepted, then dia stays 0 (full); raising doa resumes transfer with no loss or duplicate; the push/pop-at-full cycle shows no write.
4. Parallel outputs:
   - stimulus: inputs 0..4 each target a distinct output with 4-flit packets;
   - response: all 5 outputs deliver 1 flit/cycle simultaneously; data order is preserved per port.
5. Bubbles and illegal request:
   - stimulus: div toggles mid-packet; dreq=5'b00110;
   - response: the lock holds across bubbles; only output 1 receives the flits.
6. Async reset mid-packet:
   - stimulus: assert rst_n=0 between clock edges;
   - response: dov, dia and obusy drop to 0 immediately; after release a new packet from input 0 is granted first.

Source files
------------

// File: rtl/clos_cm_sync_buf.sv
// Buffered Clos centre module: KN x KN wormhole crossbar with per-output
// round-robin packet lock and a BD-deep output FIFO decoupling OM back-pressure.

module clos_cm_oport #(
  parameter int KN = 5,
  parameter int DW = 8,
  parameter int BD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KN-1:0]         req,
  input  logic [KN-1:0]         div,
  input  logic [KN-1:0]         di4,
  input  logic [KN-1:0][DW-1:0] di,
  input  logic                  doa,
  output logic [DW-1:0]         dout,
  output logic                  do4,
  output logic                  dov,
  output logic                  obusy,
  output logic [KN-1:0]         ack
);
  localparam int PW = (KN > 1) ? $clog2(KN) : 1;
  localparam int AW = (BD > 1) ? $clog2(BD) : 1;
  localparam int CW = $clog2(BD + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] owner, owner_nx, ptr, ptr_nx, pick, cand;
  logic          any;
  logic [CW-1:0] cnt;
  logic [AW-1:0] wptr, rptr;
  logic [DW:0]   mem [BD];
  logic          full, push, pop;

  assign full  = (cnt == CW'(BD));
  assign dov   = (cnt != '0);
  assign pop   = dov & doa;
  assign obusy = (state == LOCKED);
  // full is the pre-pop count, so a full FIFO never takes a write even while popping
  assign push  = obusy & div[owner] & ~full;

  // first requester strictly after ptr, scanning upward; descending loop so nearest wins
  always_comb begin
    pick = ptr;
    any  = 1'b0;
    cand = '0;
    for (int off = KN; off >= 1; off--) begin
      cand = PW'((int'(ptr) + off) % KN);
      if (req[cand]) begin
        pick = cand;
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    case (state)
      IDLE:    if (any) begin
                 state_nx = LOCKED;
                 owner_nx = pick;
               end
      LOCKED:  if (push && di4[owner]) begin
                 state_nx = IDLE;
                 ptr_nx   = owner;
               end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (obusy && !full) ack[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= PW'(KN - 1);
      cnt   <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {di4[owner], di[owner]};
  end

  assign dout = dov ? mem[rptr][DW-1:0] : '0;
  assign do4  = dov & mem[rptr][DW];
endmodule

module clos_cm_sync_buf #(
  parameter int KN = 5,
  parameter int DW = 8,
  parameter int BD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KN*DW-1:0] di,
  input  logic [KN-1:0]    di4,
  input  logic [KN-1:0]    div,
  input  logic [KN*KN-1:0] dreq,
  output logic [KN-1:0]    dia,
  output logic [KN*DW-1:0] dout,
  output logic [KN-1:0]    do4,
  output logic [KN-1:0]    dov,
  input  logic [KN-1:0]    doa,
  output logic [KN-1:0]    obusy
);
  logic [KN-1:0][DW-1:0] din_a, dout_a;
  logic [KN-1:0][KN-1:0] rq_a, oh, req_t, ack_a;

  assign din_a = di;
  assign rq_a  = dreq;
  assign dout  = dout_a;

  genvar gi, gj;
  generate
    for (gi = 0; gi < KN; gi++) begin : g_req
      // illegal multi-hot requests collapse to their lowest set bit
      assign oh[gi] = rq_a[gi] & (~rq_a[gi] + KN'(1));
      for (gj = 0; gj < KN; gj++) begin : g_col
        assign req_t[gj][gi] = div[gi] & oh[gi][gj];
      end
    end

    for (gj = 0; gj < KN; gj++) begin : g_op
      clos_cm_oport #(.KN(KN), .DW(DW), .BD(BD)) u_op (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_t[gj]),
        .div   (div),
        .di4   (di4),
        .di    (din_a),
        .doa   (doa[gj]),
        .dout  (dout_a[gj]),
        .do4   (do4[gj]),
        .dov   (dov[gj]),
        .obusy (obusy[gj]),
        .ack   (ack_a[gj])
      );
    end
  endgenerate

  always_comb begin
    dia = '0;
    for (int j = 0; j < KN; j++) dia = dia | ack_a[j];
  end
endmodule

// File: tb/tb_clos_cm_sync_buf.sv
// Directed bench for clos_cm_sync_buf: lock timing, round-robin order,
// back-pressure, parallel outputs, bubbles/illegal request, async reset.

module tb_clos_cm_sync_buf;
  localparam int KN = 5;
  localparam int DW = 8;
  localparam int BD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [KN*DW-1:0] di, dout;
  logic [KN-1:0]    di4, div, dia, do4, dov, doa, obusy;
  logic [KN*KN-1:0] dreq;

  int npass = 0;
  int ntot  = 0;
  logic [DW:0] rx [KN][$];
  logic [DW:0] ex [$];

  clos_cm_sync_buf #(.KN(KN), .DW(DW), .BD(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .di    (di),
    .di4   (di4),
    .div   (div),
    .dreq  (dreq),
    .dia   (dia),
    .dout  (dout),
    .do4   (do4),
    .dov   (dov),
    .doa   (doa),
    .obusy (obusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // record every flit the OM side accepts
  always @(negedge clk)
    for (int j = 0; j < KN; j++)
      if (dov[j] && doa[j]) rx[j].push_back({do4[j], dout[j*DW +: DW]});

  task automatic send(input int i, input logic [KN-1:0] rq, input int n,
                      input logic [DW-1:0] base, input int stp, input bit bub);
    bit done;
    for (int f = 0; f < n; f++) begin
      if (bub && f > 0) begin
        div[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      di[i*DW +: DW]   = base + DW'(f * stp);
      di4[i]           = (f == n - 1);
      div[i]           = 1'b1;
      dreq[i*KN +: KN] = rq;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
        @(negedge clk);
        done = dia[i];
        @(posedge clk);
        #1;
      end
      if (!done) begin
        chk($sformatf("send_timeout_in%0d", i), 0, 1);
        break;
      end
    end
    div[i]           = 1'b0;
    di4[i]           = 1'b0;
    dreq[i*KN +: KN] = '0;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int j = 0; j < KN; j++) rx[j].delete();
  endtask

  task automatic chk_rx(input string tag, input int j);
    chk({tag, "_n"}, rx[j].size(), ex.size());
    for (int k = 0; k < ex.size() && k < rx[j].size(); k++)
      chk($sformatf("%s_%0d", tag, k), rx[j][k], ex[k]);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    di = '0; di4 = '0; div = '0; dreq = '0; doa = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dov", dov, 0);
    chk("rst_dia", dia, 0);
    chk("rst_busy", obusy, 0);
    chk("rst_do", dout, 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single 3-flit packet, input 2 -> output 4
    fork
      send(2, 5'b10000, 3, 8'h11, 8'h11, 1'b0);
      begin
        @(posedge clk); #2;
        chk("t1_busy_c1", obusy, 5'b10000);
        chk("t1_dov_c1", dov, 0);
        chk("t1_dia_c1", dia, 5'b00100);
        @(posedge clk); #2;
        chk("t1_dov_c2", dov, 5'b10000);
        chk("t1_do_c2", dout[4*DW +: DW], 8'h11);
        @(posedge clk); #2;
        chk("t1_do_c3", {do4[4], dout[4*DW +: DW]}, 9'h022);
        chk("t1_busy_c3", obusy, 5'b10000);
        @(posedge clk); #2;
        chk("t1_do_c4", {do4[4], dout[4*DW +: DW]}, 9'h133);
        chk("t1_busy_c4", obusy, 0);
      end
    join
    settle();
    ex = '{9'h011, 9'h022, 9'h133};
    chk_rx("t1", 4);
    clr();

    // contention on output 1: reset pointer favours 0, then 1, then 3
    fork
      send(0, 5'b00010, 2, 8'hA0, 1, 1'b0);
      send(1, 5'b00010, 2, 8'hB0, 1, 1'b0);
      send(3, 5'b00010, 2, 8'hD0, 1, 1'b0);
    join
    settle();
    ex = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0D0, 9'h1D1};
    chk_rx("t2", 1);
    clr();
    // pointer now at 3, so input 4 beats input 0
    fork
      send(0, 5'b00010, 1, 8'hA8, 1, 1'b0);
      send(4, 5'b00010, 1, 8'hE8, 1, 1'b0);
    join
    settle();
    ex = '{9'h1E8, 9'h1A8};
    chk_rx("t2p", 1);
    clr();

    // back-pressure: output 0 stalled while a 6-flit packet arrives
    doa[0] = 1'b0;
    fork
      send(2, 5'b00001, 6, 8'h60, 1, 1'b0);
      begin
        repeat (8) @(posedge clk); #2;
        chk("t3_full_dia", dia, 0);
        chk("t3_full_dov", dov, 5'b00001);
        chk("t3_busy", obusy, 5'b00001);
        chk("t3_head", dout[0 +: DW], 8'h60);
        doa[0] = 1'b1;
        #1;
        chk("t3_popfull_dia", dia, 0);
        @(posedge clk); #2;
        chk("t3_resume_dia", dia, 5'b00100);
        chk("t3_resume_head", dout[0 +: DW], 8'h61);
      end
    join
    settle();
    ex = '{9'h060, 9'h061, 9'h062, 9'h063, 9'h064, 9'h165};
    chk_rx("t3", 0);
    clr();

    // parallel: input i -> output (i+1)%5, all streaming together
    fork
      send(0, 5'b00010, 4, 8'h40, 1, 1'b0);
      send(1, 5'b00100, 4, 8'h50, 1, 1'b0);
      send(2, 5'b01000, 4, 8'h60, 1, 1'b0);
      send(3, 5'b10000, 4, 8'h70, 1, 1'b0);
      send(4, 5'b00001, 4, 8'h80, 1, 1'b0);
      begin
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); #2;
          chk($sformatf("t4_dov_c%0d", c + 2), dov, 5'h1f);
          chk($sformatf("t4_do_c%0d", c + 2), dout, 64'h70_60_50_40_80 + 64'h01_01_01_01_01 * c);
        end
      end
    join
    settle();
    ex = '{9'h040, 9'h041, 9'h042, 9'h143};
    chk_rx("t4o1", 1);
    ex = '{9'h080, 9'h081, 9'h082, 9'h183};
    chk_rx("t4o0", 0);
    clr();

    // bubbles between flits and a multi-hot request that resolves to output 1
    fork
      send(3, 5'b00110, 4, 8'h90, 1, 1'b1);
      begin
        repeat (3) @(posedge clk); #2;
        chk("t5_lock", obusy, 5'b00010);
        chk("t5_dia", dia, 5'b01000);
      end
    join
    settle();
    ex = '{9'h090, 9'h091, 9'h092, 9'h193};
    chk_rx("t5", 1);
    chk("t5_o2_n", rx[2].size(), 0);
    clr();

    // async reset mid-packet, then check the reset pointer favours input 0
    doa[2] = 1'b0;
    di[0 +: DW] = 8'h70; di4[0] = 1'b0; div[0] = 1'b1; dreq[0 +: KN] = 5'b00100;
    repeat (3) @(posedge clk);
    #3;
    chk("t6_pre_busy", obusy, 5'b00100);
    chk("t6_pre_dov", dov, 5'b00100);
    rst_n = 1'b0;
    #1;
    chk("t6_dov", dov, 0);
    chk("t6_dia", dia, 0);
    chk("t6_busy", obusy, 0);
    div = '0; dreq = '0; di4 = '0; doa = '1;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      send(0, 5'b01000, 1, 8'hC0, 1, 1'b0);
      send(4, 5'b01000, 1, 8'hC4, 1, 1'b0);
    join
    settle();
    ex = '{9'h1C0, 9'h1C4};
    chk_rx("t6", 3);
    chk("t6_o2_n", rx[2].size(), 0);
    clr();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
